// File: rtl/sig_gen_pkg.sv
// sig_gen_pkg: shared types, default width and zero-clamp helper for the test-signal generator.
package sig_gen_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam int CNT_W_DEF = 32;
    function automatic logic [63:0] clamp1(input logic [63:0] v);
        return (v == '0) ? 64'd1 : v;
    endfunction
endpackage

// File: rtl/sig_gen_if.sv
// sig_gen_if: configuration/status bundle between the register file (master) and the generator (slave).
interface sig_gen_if #(parameter int CNT_W = 32);
    logic             gen_en_i;
    logic             cfg_wr_en_i;
    logic [CNT_W-1:0] high_cnt_i;
    logic [CNT_W-1:0] low_cnt_i;
    logic [CNT_W-1:0] burst_total_i;
    logic             sig_clk_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] period_cnt_o;
    modport master (
        output gen_en_i, cfg_wr_en_i, high_cnt_i, low_cnt_i, burst_total_i,
        input  sig_clk_o, busy_o, done_o, period_cnt_o
    );
    modport slave (
        input  gen_en_i, cfg_wr_en_i, high_cnt_i, low_cnt_i, burst_total_i,
        output sig_clk_o, busy_o, done_o, period_cnt_o
    );
endinterface

// File: rtl/sig_gen.sv
// sig_gen: programmable square-wave generator with high/low time, burst length and graceful stop.
module sig_gen
    import sig_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    sig_gen_if.slave bus
);
    state_t           state;
    logic             halted;
    logic [CNT_W-1:0] sh_hi, sh_lo, sh_burst, lo, burst, cnt;
    logic [CNT_W-1:0] nxt_hi, nxt_lo, nxt_burst, pc_inc;
    logic             last_low, hit, fin, start;
    // A write landing on a period boundary bypasses the shadow so it applies to the new period.
    always_comb begin
        nxt_hi    = bus.cfg_wr_en_i ? CNT_W'(clamp1(64'(bus.high_cnt_i))) : sh_hi;
        nxt_lo    = bus.cfg_wr_en_i ? CNT_W'(clamp1(64'(bus.low_cnt_i))) : sh_lo;
        nxt_burst = bus.cfg_wr_en_i ? bus.burst_total_i : sh_burst;
        pc_inc    = bus.period_cnt_o + CNT_W'(1);
        last_low  = (state == LOW) && (cnt == '0);
        hit       = (burst != '0) && (pc_inc == burst);
        fin       = last_low && (hit || !bus.gen_en_i);
        start     = (state == IDLE) ? (bus.gen_en_i && !halted) : (last_low && !fin);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= IDLE;
            halted           <= 1'b0;
            sh_hi            <= CNT_W'(1);
            sh_lo            <= CNT_W'(1);
            sh_burst         <= '0;
            lo               <= CNT_W'(1);
            burst            <= '0;
            cnt              <= '0;
            bus.sig_clk_o    <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.period_cnt_o <= '0;
        end else begin
            bus.done_o <= 1'b0;
            if (bus.cfg_wr_en_i) begin
                sh_hi    <= nxt_hi;
                sh_lo    <= nxt_lo;
                sh_burst <= nxt_burst;
            end
            if (!bus.gen_en_i) halted <= 1'b0;
            if (start) begin
                state            <= HIGH;
                bus.sig_clk_o    <= 1'b1;
                bus.busy_o       <= 1'b1;
                cnt              <= nxt_hi - CNT_W'(1);
                lo               <= nxt_lo;
                burst            <= nxt_burst;
                bus.period_cnt_o <= (state == IDLE) ? '0 : pc_inc;
            end else if (fin) begin
                state            <= IDLE;
                bus.busy_o       <= 1'b0;
                bus.done_o       <= 1'b1;
                bus.period_cnt_o <= pc_inc;
                halted           <= bus.gen_en_i && hit;
            end else if (state == HIGH && cnt == '0) begin
                state         <= LOW;
                bus.sig_clk_o <= 1'b0;
                cnt           <= lo - CNT_W'(1);
            end else if (state != IDLE) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sig_gen.sv
// tb_sig_gen: directed checks of sig_gen waveform, burst, reconfiguration, stop and reset behaviour.
module tb_sig_gen;
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    string exp4 = "101010111100001111000011011";
    always #5 clk_i = ~clk_i;
    sig_gen_if #(.CNT_W(32)) bus ();
    sig_gen #(.CNT_W(32)) dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask
    task automatic cfg(input logic [31:0] h, input logic [31:0] l, input logic [31:0] b);
        bus.cfg_wr_en_i   = 1'b1;
        bus.high_cnt_i    = h;
        bus.low_cnt_i     = l;
        bus.burst_total_i = b;
        step();
        bus.cfg_wr_en_i = 1'b0;
    endtask
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30 && bus.busy_o; i++) step();
        chk(tag, 64'(bus.busy_o), 64'd0);
    endtask
    initial begin
        bus.gen_en_i      = 1'b0;
        bus.cfg_wr_en_i   = 1'b0;
        bus.high_cnt_i    = '0;
        bus.low_cnt_i     = '0;
        bus.burst_total_i = '0;
        step();
        step();
        chk("rst_sig", 64'(bus.sig_clk_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_pc", 64'(bus.period_cnt_o), 64'd0);
        rst_n_i = 1'b1;
        // Continuous 2/3, then stop mid-period.
        cfg(2, 3, 0);
        bus.gen_en_i = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            step();
            chk("cont_sig", 64'(bus.sig_clk_o), 64'((k % 5) < 2));
        end
        chk("cont_pc", 64'(bus.period_cnt_o), 64'd4);
        chk("cont_busy", 64'(bus.busy_o), 64'd1);
        bus.gen_en_i = 1'b0;
        for (int k = 21; k <= 25; k++) begin
            step();
            chk("stop_sig", 64'(bus.sig_clk_o), 64'(k < 22));
            chk("stop_done", 64'(bus.done_o), 64'(k == 25));
        end
        chk("stop_pc", 64'(bus.period_cnt_o), 64'd5);
        chk("stop_busy", 64'(bus.busy_o), 64'd0);
        step();
        chk("stop_done_clr", 64'(bus.done_o), 64'd0);
        chk("stop_pc_hold", 64'(bus.period_cnt_o), 64'd5);
        // Burst of 4 with 1/1.
        cfg(1, 1, 4);
        bus.gen_en_i = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step();
            chk("burst_sig", 64'(bus.sig_clk_o), 64'(k < 8 && (k % 2) == 0));
            chk("burst_done", 64'(bus.done_o), 64'(k == 8));
            chk("burst_busy", 64'(bus.busy_o), 64'(k < 8));
        end
        chk("burst_pc", 64'(bus.period_cnt_o), 64'd4);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("burst_halt", 64'(bus.busy_o), 64'd0);
        end
        bus.gen_en_i = 1'b0;
        step();
        bus.gen_en_i = 1'b1;
        step();
        chk("burst_restart", 64'(bus.sig_clk_o), 64'd1);
        chk("burst_restart_pc", 64'(bus.period_cnt_o), 64'd0);
        bus.gen_en_i = 1'b0;
        step();
        step();
        chk("burst_stop_done", 64'(bus.done_o), 64'd1);
        chk("burst_stop_pc", 64'(bus.period_cnt_o), 64'd1);
        // Zero clamp, mid-period write, boundary bypass write.
        cfg(0, 0, 0);
        bus.gen_en_i = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            bus.cfg_wr_en_i = (k == 5) || (k == 22);
            bus.high_cnt_i  = (k == 22) ? 32'd2 : 32'd4;
            bus.low_cnt_i   = (k == 22) ? 32'd1 : 32'd4;
            step();
            chk("recfg_sig", 64'(bus.sig_clk_o), 64'(exp4[k] == 8'h31));
        end
        bus.cfg_wr_en_i = 1'b0;
        chk("recfg_pc", 64'(bus.period_cnt_o), 64'd6);
        bus.gen_en_i = 1'b0;
        wait_idle("recfg_idle");
        chk("recfg_end_low", 64'(bus.sig_clk_o), 64'd0);
        // Stop during HIGH of a 5/5 period.
        cfg(5, 5, 0);
        bus.gen_en_i = 1'b1;
        step();
        step();
        bus.gen_en_i = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            step();
            chk("midhi_sig", 64'(bus.sig_clk_o), 64'(k < 5));
            chk("midhi_done", 64'(bus.done_o), 64'(k == 10));
            chk("midhi_busy", 64'(bus.busy_o), 64'(k < 10));
        end
        chk("midhi_pc", 64'(bus.period_cnt_o), 64'd1);
        // Asynchronous reset during LOW.
        bus.gen_en_i = 1'b1;
        for (int k = 0; k <= 6; k++) step();
        chk("prerst_sig", 64'(bus.sig_clk_o), 64'd0);
        chk("prerst_busy", 64'(bus.busy_o), 64'd1);
        rst_n_i = 1'b0;
        #1;
        chk("arst_sig", 64'(bus.sig_clk_o), 64'd0);
        chk("arst_busy", 64'(bus.busy_o), 64'd0);
        chk("arst_pc", 64'(bus.period_cnt_o), 64'd0);
        step();
        chk("arst_done", 64'(bus.done_o), 64'd0);
        rst_n_i = 1'b1;
        chk("arst_rel_sig", 64'(bus.sig_clk_o), 64'd0);
        step();
        chk("arst_first_hi", 64'(bus.sig_clk_o), 64'd1);
        chk("arst_first_busy", 64'(bus.busy_o), 64'd1);
        step();
        chk("arst_shadow_hi1", 64'(bus.sig_clk_o), 64'd0);
        bus.gen_en_i = 1'b0;
        wait_idle("arst_idle");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
